// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad and presents a debounced key code
// together with a clean "key held" level for the calculator control unit.
// One column is driven low at a time. The rows are brought into the clock
// domain through a two-flop synchronizer. A press and a release are each
// accepted only after the row pattern has stayed put for DEBOUNCE_CYCLES
// consecutive cycles.
//
// Parameters:
//   SCAN_DIV        - cycles each column is driven before its rows are judged
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept press/release
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   row_n[3:0] in   keypad rows, active-low, asynchronous to clock
//   col_n[3:0] out  column drive, active-low one-hot
//   button[3:0] out key code of the last accepted key (0-9, A-F)
//   is_pressed out  high while a debounced key is held
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] button,
    output logic       is_pressed
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_next;
    logic [DEB_W-1:0]   deb_cnt;
    logic [DEB_W-1:0]   deb_next;
    logic [3:0]         col_next;
    logic [1:0]         col_idx;
    logic [1:0]         col_idx_next;
    logic [3:0]         row_pat;
    logic [3:0]         pat_next;
    logic [3:0]         button_next;
    logic               pressed_next;

    logic [3:0]         row_meta;
    logic [3:0]         row_s;
    logic [1:0]         active_col;
    logic [1:0]         hit_row;
    logic [3:0]         key_code;
    logic [3:0]         col_rot;

    // Key legend indexed by (row, column) of the switch that closed.
    function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hF;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs. Idle rows read
    // high, so the flops reset to all ones to avoid a phantom key at startup.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_s    <= row_meta;
        end
    end

    // Column index of the currently driven column, plus the next column in
    // the rotation (the low bit walks towards the MSB and wraps).
    always_comb begin
        case (col_n)
            4'b1110: active_col = 2'd0;
            4'b1101: active_col = 2'd1;
            4'b1011: active_col = 2'd2;
            4'b0111: active_col = 2'd3;
            default: active_col = 2'd0;
        endcase
        col_rot = {col_n[2:0], col_n[3]};
    end

    // When several rows of the latched pattern are low, the lowest row wins.
    always_comb begin
        hit_row = 2'd3;
        if (!row_pat[0]) begin
            hit_row = 2'd0;
        end else if (!row_pat[1]) begin
            hit_row = 2'd1;
        end else if (!row_pat[2]) begin
            hit_row = 2'd2;
        end
        key_code = encode(hit_row, col_idx);
    end

    // State register and all datapath registers. Everything is loaded from
    // the next-state logic below so outputs are registered and glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            dwell      <= '0;
            deb_cnt    <= '0;
            col_n      <= 4'b1110;
            col_idx    <= 2'd0;
            row_pat    <= 4'hF;
            button     <= 4'h0;
            is_pressed <= 1'b0;
        end else begin
            state      <= state_next;
            dwell      <= dwell_next;
            deb_cnt    <= deb_next;
            col_n      <= col_next;
            col_idx    <= col_idx_next;
            row_pat    <= pat_next;
            button     <= button_next;
            is_pressed <= pressed_next;
        end
    end

    // Next-state logic. The column drive stays frozen from the moment a
    // closed switch is seen until the release has been fully debounced, so
    // the code cannot change while a key is down. A return to SCAN after a
    // debounced release keeps the same column and restarts its dwell.
    always_comb begin
        state_next   = state;
        dwell_next   = dwell;
        deb_next     = deb_cnt;
        col_next     = col_n;
        col_idx_next = col_idx;
        pat_next     = row_pat;
        button_next  = button;
        pressed_next = is_pressed;

        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (row_s == 4'hF) begin
                        col_next = col_rot;
                    end else begin
                        col_idx_next = active_col;
                        pat_next     = row_s;
                        deb_next     = '0;
                        state_next   = DEB_PRESS;
                    end
                end else begin
                    dwell_next = dwell + DWELL_W'(1);
                end
            end

            DEB_PRESS: begin
                if (row_s != row_pat) begin
                    state_next = SCAN;
                    col_next   = col_rot;
                    dwell_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next   = PRESSED;
                    button_next  = key_code;
                    pressed_next = 1'b1;
                end else begin
                    deb_next = deb_cnt + DEB_W'(1);
                end
            end

            PRESSED: begin
                if (row_s == 4'hF) begin
                    state_next = DEB_RELEASE;
                    deb_next   = '0;
                end
            end

            DEB_RELEASE: begin
                if (row_s != 4'hF) begin
                    state_next = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next   = SCAN;
                    dwell_next   = '0;
                    pressed_next = 1'b0;
                end else begin
                    deb_next = deb_cnt + DEB_W'(1);
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner. A behavioural keypad (a 16-bit
// map of closed switches) produces row_n from the column drive. Every press
// that should be accepted pushes its expected code into a queue; a monitor
// pops one entry on each rising edge of is_pressed and compares button.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int PRESS_LIMIT     = 4 * SCAN_DIV + 2 + DEBOUNCE_CYCLES + 1;

    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hF, 4'h0, 4'hE, 4'hD
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  button;
    logic        is_pressed;

    logic [15:0] keys = '0;
    logic [3:0]  expected_q [$];
    int          checks = 0;
    int          errors = 0;
    int          press_count = 0;

    logic        prev_pressed = 1'b0;
    logic [3:0]  held_code = 4'h0;
    int          low_len = 0;
    bit          seen_fall = 1'b0;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .row_n      (row_n),
        .col_n      (col_n),
        .button     (button),
        .is_pressed (is_pressed)
    );

    always #5 clock = ~clock;

    // Physical keypad: a row reads low when any closed switch on it sits in
    // a column that is currently driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    // Range comparison; equality is the case lo == hi.
    task automatic checkOutput(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            if (lo == hi) begin
                $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, lo);
            end else begin
                $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
            end
        end
    endtask

    // Expected code: first column by index, then lowest closed row in it.
    function automatic logic [3:0] refCode(input logic [15:0] k);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (k[r*4+c]) begin
                    return KEY_MAP[r*4+c];
                end
            end
        end
        return 4'h0;
    endfunction

    function automatic logic [15:0] keyBit(input int r, input int c);
        logic [15:0] one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    function automatic logic [3:0] colDrive(input int c);
        logic [3:0] one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic applyStimulus(input logic [15:0] k);
        @(negedge clock);
        keys = k;
    endtask

    task automatic waitLevel(input logic level, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (is_pressed !== level && cycles < limit);
        if (is_pressed !== level) begin
            cycles = limit + 1;
        end
    endtask

    task automatic pressKeys(input logic [15:0] k);
        int lat;
        expected_q.push_back(refCode(k));
        applyStimulus(k);
        waitLevel(1'b1, 60, lat);
        checkOutput("press latency", lat, 1, PRESS_LIMIT);
    endtask

    task automatic releaseKeys();
        int cyc;
        applyStimulus('0);
        waitLevel(1'b0, 40, cyc);
        checkOutput("release delay", cyc, DEBOUNCE_CYCLES, DEBOUNCE_CYCLES + 3);
    endtask

    task automatic holdCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: pops one expected code per accepted press, then checks that
    // the code stays put while the key is held and that consecutive presses
    // are separated by a low gap of at least one dwell period.
    always @(negedge clock) begin
        if (reset) begin
            prev_pressed = 1'b0;
            seen_fall    = 1'b0;
        end else begin
            if (is_pressed && !prev_pressed) begin
                press_count++;
                if (seen_fall) begin
                    checkOutput("release gap", low_len, SCAN_DIV, 1 << 30);
                end
                if (expected_q.size() == 0) begin
                    checkOutput("unexpected press", 1, 0, 0);
                end else begin
                    held_code = expected_q.pop_front();
                    checkOutput("press code", int'(button), int'(held_code), int'(held_code));
                end
            end else if (is_pressed && prev_pressed) begin
                checkOutput("held code", int'(button), int'(held_code), int'(held_code));
            end
            if (!is_pressed && prev_pressed) begin
                seen_fall = 1'b1;
                low_len   = 0;
            end
            if (!is_pressed) begin
                low_len++;
            end
            prev_pressed = is_pressed;
        end
    end

    // Main stimulus sequence.
    initial begin
        logic [15:0] k_e;
        logic [15:0] k_a;
        logic [15:0] k_0;
        int          base;
        int          lat;
        int          r;
        int          c;

        k_e = keyBit(3, 2);
        k_a = keyBit(0, 3);
        k_0 = keyBit(3, 1);

        repeat (3) @(negedge clock);
        checkOutput("reset col_n", int'(col_n), 14, 14);
        checkOutput("reset button", int'(button), 0, 0);
        checkOutput("reset is_pressed", int'(is_pressed), 0, 0);
        reset = 1'b0;

        // Idle scan: column advances every SCAN_DIV clocks and wraps.
        for (int k = 1; k <= 5 * 4 * SCAN_DIV / 2; k++) begin
            @(negedge clock);
            checkOutput("scan col_n", int'(col_n), int'(colDrive((k / SCAN_DIV) % 4)),
                        int'(colDrive((k / SCAN_DIV) % 4)));
            checkOutput("idle is_pressed", int'(is_pressed), 0, 0);
        end

        // Key "5": column must stay frozen while held.
        pressKeys(keyBit(1, 1));
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checkOutput("held col_n", int'(col_n), int'(colDrive(1)), int'(colDrive(1)));
        end
        releaseKeys();
        holdCycles(20);

        // Key "E" with 3-cycle bounces before settling.
        base = press_count;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            keys = (((i / 3) % 2) == 0) ? k_e : 16'h0;
            checkOutput("bounce is_pressed", int'(is_pressed), 0, 0);
        end
        pressKeys(k_e);
        holdCycles(10);
        releaseKeys();
        checkOutput("bounce press count", press_count - base, 1, 1);
        holdCycles(20);

        // Key "A" with a 2-cycle re-close during release.
        base = press_count;
        pressKeys(k_a);
        holdCycles(5);
        applyStimulus('0);
        checkOutput("glitch is_pressed", int'(is_pressed), 1, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checkOutput("glitch is_pressed", int'(is_pressed), 1, 1);
        end
        applyStimulus(k_a);
        checkOutput("glitch is_pressed", int'(is_pressed), 1, 1);
        @(negedge clock);
        checkOutput("glitch is_pressed", int'(is_pressed), 1, 1);
        releaseKeys();
        holdCycles(20);
        checkOutput("glitch press count", press_count - base, 1, 1);

        // Keys "1" and "4" together; dropping "1" must not change the code.
        pressKeys(keyBit(0, 0) | keyBit(1, 0));
        holdCycles(5);
        applyStimulus(keyBit(1, 0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("multi button", int'(button), 1, 1);
            checkOutput("multi is_pressed", int'(is_pressed), 1, 1);
        end
        releaseKeys();
        holdCycles(20);

        // Reset while "0" is held, then re-detection.
        pressKeys(k_0);
        holdCycles(5);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset is_pressed", int'(is_pressed), 0, 0);
        checkOutput("midreset button", int'(button), 0, 0);
        checkOutput("midreset col_n", int'(col_n), 14, 14);
        holdCycles(3);
        reset = 1'b0;
        expected_q.push_back(refCode(keys));
        waitLevel(1'b1, 60, lat);
        checkOutput("redetect latency", lat, 1, PRESS_LIMIT);
        holdCycles(5);
        releaseKeys();
        holdCycles(20);

        // Randomized single-key presses.
        for (int n = 0; n < 12; n++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            pressKeys(keyBit(r, c));
            holdCycles(int'($urandom_range(5, 25)));
            releaseKeys();
            holdCycles(int'($urandom_range(3, 12)));
        end

        holdCycles(2);
        checkOutput("scoreboard drained", expected_q.size(), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case the sequence itself stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
